// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller: states, opcodes,
// ALU operations, datapath select codes and trap causes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_TRAP     = 4'd9
  } state_e;

  typedef enum logic {
    ALUOP_ADD   = 1'b0,
    ALUOP_FUNCT = 1'b1
  } alu_op_e;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle. master = controller side.
interface multicycle_controller_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             mem_ready;
  logic             mem_req;
  logic             MemWrite;
  logic             IRWrite;
  logic             PCWrite;
  logic             AdrSrc;
  logic             RegWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUControl;
  logic             ImmSrc;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  op, funct3, funct7b5, mem_ready,
    output mem_req, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, trap, trap_cause, instr_count
  );

  modport slave (
    output op, funct3, funct7b5, mem_ready,
    input  mem_req, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, trap, trap_cause, instr_count
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode; illegal flags funct3 values the core does not implement.
module multicycle_controller_alu_decoder
  import multicycle_controller_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic       op_b5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control,
  output logic       illegal
);

  logic [2:0] funct_ctrl;

  always_comb begin
    funct_ctrl = ALU_ADD;
    illegal    = 1'b0;
    case (funct3)
      3'b000:  funct_ctrl = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_ctrl = ALU_SLT;
      3'b110:  funct_ctrl = ALU_OR;
      3'b111:  funct_ctrl = ALU_AND;
      default: illegal    = 1'b1;
    endcase
    alu_control = (alu_op == ALUOP_FUNCT) ? funct_ctrl : ALU_ADD;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I core: sequencing, memory
// handshake with timeout, retired-instruction count and sticky trap.
//
// state      | meaning
// FETCH      | read instruction at PC, PC += 4
// DECODE     | classify opcode, OldPC + imm precomputed
// MEMADR     | rs1 + imm address for load/store
// MEMREAD    | load data read, wait for mem_ready
// MEMWB      | write load data to rd, retire
// MEMWRITE   | store write, retire on mem_ready
// EXECR      | rs1 op rs2
// EXECI      | rs1 op imm
// ALUWB      | write ALU result to rd, retire
// TRAP       | halted until reset
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_mem, retire, illegal_funct;
  logic [2:0]         alu_control;
  alu_op_e            alu_op;

  assign alu_op = (state_q == S_EXECR || state_q == S_EXECI) ? ALUOP_FUNCT : ALUOP_ADD;
  assign in_mem = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);

  multicycle_controller_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .op_b5       (bus.op[5]),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .alu_control (alu_control),
    .illegal     (illegal_funct)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = illegal_funct ? S_TRAP : S_EXECR;
          OP_I:         state_d = illegal_funct ? S_TRAP : S_EXECI;
          default:      state_d = S_TRAP;
        endcase
        if (state_d == S_TRAP) cause_d = CAUSE_ILLEGAL;
      end
      S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: if (bus.mem_ready) begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_ALUWB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default:    state_d = S_TRAP;
    endcase

    // Counter stays zero outside a stalled memory state, so every entry starts clean.
    wait_d = '0;
    if (in_mem && !bus.mem_ready) begin
      if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
        state_d = S_TRAP;
        cause_d = CAUSE_TIMEOUT;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end

    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ResultSrc  = RES_ALUOUT;
    bus.ALUSrcA    = SRCA_PC;
    bus.ALUSrcB    = SRCB_RD2;
    bus.ALUControl = alu_control;
    bus.ImmSrc     = (bus.op == OP_SW);
    case (state_q)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.IRWrite   = 1'b1;
          bus.PCWrite   = 1'b1;
          bus.ALUSrcA   = SRCA_PC;
          bus.ALUSrcB   = SRCB_FOUR;
          bus.ResultSrc = RES_ALURESULT;
        end
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEMADR, S_EXECI: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        bus.ResultSrc = RES_DATA;
        bus.RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        bus.mem_req  = 1'b1;
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = bus.mem_ready;
      end
      S_EXECR: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_RD2;
      end
      S_ALUWB: begin
        bus.ResultSrc = RES_ALUOUT;
        bus.RegWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.trap        = (state_q == S_TRAP);
  assign bus.trap_cause  = cause_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle expected outputs come from a
// state-sequence model and are queued, then checked against the DUT at negedge.
module tb_multicycle_controller;

  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned CNT_W       = 4;

  localparam logic [6:0] T_OP_LW = 7'b0000011;
  localparam logic [6:0] T_OP_SW = 7'b0100011;
  localparam logic [6:0] T_OP_R  = 7'b0110011;
  localparam logic [6:0] T_OP_I  = 7'b0010011;

  typedef enum int {T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB,
                    T_MEMWRITE, T_EXECR, T_EXECI, T_ALUWB, T_TRAP} tst_e;

  typedef struct packed {
    logic             mem_req;
    logic             MemWrite;
    logic             IRWrite;
    logic             PCWrite;
    logic             AdrSrc;
    logic             RegWrite;
    logic [1:0]       ResultSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       ALUControl;
    logic             ImmSrc;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instr_count;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if #(.CNT_W(CNT_W)) bus ();

  multicycle_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  obs_t sb[$];
  obs_t obs, expv;
  logic [CNT_W-1:0] exp_cnt;
  logic [1:0]       exp_cause;

  function automatic logic [2:0] alu_exp(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (op == T_OP_R && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic obs_t expect_obs(input tst_e s, input logic rdy, input logic [6:0] op,
                                      input logic [2:0] f3, input logic f7,
                                      input logic [1:0] cause, input logic [CNT_W-1:0] cnt);
    obs_t o = '0;
    o.ImmSrc      = (op == T_OP_SW);
    o.trap_cause  = cause;
    o.instr_count = cnt;
    case (s)
      T_FETCH: begin
        o.mem_req = 1'b1;
        if (rdy) begin
          o.IRWrite = 1'b1; o.PCWrite = 1'b1; o.ALUSrcB = 2'b10; o.ResultSrc = 2'b10;
        end
      end
      T_DECODE:   begin o.ALUSrcA = 2'b01; o.ALUSrcB = 2'b01; end
      T_MEMADR:   begin o.ALUSrcA = 2'b10; o.ALUSrcB = 2'b01; end
      T_MEMREAD:  begin o.mem_req = 1'b1; o.AdrSrc = 1'b1; end
      T_MEMWB:    begin o.ResultSrc = 2'b01; o.RegWrite = 1'b1; end
      T_MEMWRITE: begin o.mem_req = 1'b1; o.AdrSrc = 1'b1; o.MemWrite = rdy; end
      T_EXECR:    begin o.ALUSrcA = 2'b10; o.ALUSrcB = 2'b00; o.ALUControl = alu_exp(op, f3, f7); end
      T_EXECI:    begin o.ALUSrcA = 2'b10; o.ALUSrcB = 2'b01; o.ALUControl = alu_exp(op, f3, f7); end
      T_ALUWB:    begin o.ResultSrc = 2'b00; o.RegWrite = 1'b1; end
      T_TRAP:     o.trap = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
  endtask

  // One clock: queue the expectation, sample at negedge, advance the count model.
  task automatic drive(input tst_e s, input logic rdy);
    bus.mem_ready = rdy;
    sb.push_back(expect_obs(s, rdy, bus.op, bus.funct3, bus.funct7b5, exp_cause, exp_cnt));
    @(negedge clk);
    obs.mem_req     = bus.mem_req;     obs.MemWrite   = bus.MemWrite;
    obs.IRWrite     = bus.IRWrite;     obs.PCWrite    = bus.PCWrite;
    obs.AdrSrc      = bus.AdrSrc;      obs.RegWrite   = bus.RegWrite;
    obs.ResultSrc   = bus.ResultSrc;   obs.ALUSrcA    = bus.ALUSrcA;
    obs.ALUSrcB     = bus.ALUSrcB;     obs.ALUControl = bus.ALUControl;
    obs.ImmSrc      = bus.ImmSrc;      obs.trap       = bus.trap;
    obs.trap_cause  = bus.trap_cause;  obs.instr_count = bus.instr_count;
    @(posedge clk);
    #1;
    if (reset) begin
      exp_cnt = '0; exp_cause = 2'b00;
    end else if (s == T_MEMWB || s == T_ALUWB || (s == T_MEMWRITE && rdy)) begin
      exp_cnt = exp_cnt + 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_cnt = '0;
    exp_cause = 2'b00;
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_instr(7'b0, 3'b0, 1'b0);
    bus.mem_ready = 1'b0;
    exp_cnt = '0;
    exp_cause = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) reset = 1'b0;
      drive(T_FETCH, 1'b0);
      expv = sb.pop_front();
      n_tests++;
      if (obs !== expv) begin n_fail++; $display("FAIL reset cyc%0d: got %h want %h", i, obs, expv); end
    end
  endtask

  task automatic test_lw();
    tst_e seq [5] = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB};
    set_instr(T_OP_LW, 3'b010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(seq[i], 1'b1);
      expv = sb.pop_front();
      n_tests++;
      if (obs !== expv) begin n_fail++; $display("FAIL lw cyc%0d: got %h want %h", i, obs, expv); end
    end
    n_tests++;
    if (bus.instr_count !== CNT_W'(1)) begin
      n_fail++; $display("FAIL lw_count: got %0d want 1", bus.instr_count);
    end
  endtask

  task automatic test_sw_wait();
    tst_e seq [7] = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMWRITE, T_MEMWRITE, T_MEMWRITE, T_MEMWRITE};
    logic rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    set_instr(T_OP_SW, 3'b010, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(seq[i], rdy[i]);
      expv = sb.pop_front();
      n_tests++;
      if (obs !== expv) begin n_fail++; $display("FAIL sw cyc%0d: got %h want %h", i, obs, expv); end
    end
    n_tests++;
    if (bus.instr_count !== CNT_W'(2)) begin
      n_fail++; $display("FAIL sw_count: got %0d want 2", bus.instr_count);
    end
  endtask

  task automatic test_alu_ops();
    logic [6:0] ops [8] = '{T_OP_R, T_OP_I, T_OP_R, T_OP_R, T_OP_R, T_OP_R, T_OP_I, T_OP_I};
    logic [2:0] f3s [8] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b010, 3'b111};
    logic       f7s [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tst_e seq [4];
    for (int k = 0; k < 8; k++) begin
      set_instr(ops[k], f3s[k], f7s[k]);
      seq = '{T_FETCH, T_DECODE, (ops[k] == T_OP_R) ? T_EXECR : T_EXECI, T_ALUWB};
      for (int i = 0; i < 4; i++) begin
        drive(seq[i], 1'b1);
        expv = sb.pop_front();
        n_tests++;
        if (obs !== expv) begin n_fail++; $display("FAIL alu%0d cyc%0d: got %h want %h", k, i, obs, expv); end
      end
    end
  endtask

  task automatic test_illegal();
    logic [6:0] ops [2] = '{7'b1111111, T_OP_R};
    logic [2:0] f3s [2] = '{3'b000, 3'b001};
    tst_e seq [7] = '{T_FETCH, T_DECODE, T_TRAP, T_TRAP, T_TRAP, T_TRAP, T_FETCH};
    logic rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      set_instr(ops[k], f3s[k], 1'b0);
      for (int i = 0; i < 7; i++) begin
        if (i == 2) exp_cause = 2'b01;
        reset = (i == 5);
        drive(seq[i], rdy[i]);
        expv = sb.pop_front();
        n_tests++;
        if (obs !== expv) begin n_fail++; $display("FAIL illegal%0d cyc%0d: got %h want %h", k, i, obs, expv); end
      end
    end
  endtask

  task automatic test_timeout();
    tst_e seq_f [6] = '{T_FETCH, T_FETCH, T_FETCH, T_FETCH, T_TRAP, T_TRAP};
    logic rdy_f [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tst_e seq_m [9] = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMREAD, T_MEMREAD, T_MEMREAD, T_TRAP, T_TRAP};
    logic rdy_m [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    set_instr(T_OP_LW, 3'b010, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) exp_cause = 2'b10;
      drive(seq_f[i], rdy_f[i]);
      expv = sb.pop_front();
      n_tests++;
      if (obs !== expv) begin n_fail++; $display("FAIL fetch_timeout cyc%0d: got %h want %h", i, obs, expv); end
    end
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i == 7) exp_cause = 2'b10;
      drive(seq_m[i], rdy_m[i]);
      expv = sb.pop_front();
      n_tests++;
      if (obs !== expv) begin n_fail++; $display("FAIL read_timeout cyc%0d: got %h want %h", i, obs, expv); end
    end
  endtask

  task automatic test_reset_memread();
    tst_e seq [9] = '{T_FETCH, T_DECODE, T_EXECI, T_ALUWB, T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_FETCH};
    logic rdy [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i == 0) set_instr(T_OP_I, 3'b000, 1'b0);
      if (i == 4) set_instr(T_OP_LW, 3'b010, 1'b0);
      reset = (i == 7);
      drive(seq[i], rdy[i]);
      expv = sb.pop_front();
      n_tests++;
      if (obs !== expv) begin n_fail++; $display("FAIL reset_memread cyc%0d: got %h want %h", i, obs, expv); end
    end
  endtask

  task automatic test_count_wrap();
    tst_e seq [4] = '{T_FETCH, T_DECODE, T_EXECI, T_ALUWB};
    do_reset();
    set_instr(T_OP_I, 3'b110, 1'b0);
    for (int k = 0; k < 17; k++) begin
      for (int i = 0; i < 4; i++) begin
        drive(seq[i], 1'b1);
        expv = sb.pop_front();
        n_tests++;
        if (obs !== expv) begin n_fail++; $display("FAIL wrap%0d cyc%0d: got %h want %h", k, i, obs, expv); end
      end
    end
    n_tests++;
    if (bus.instr_count !== CNT_W'(1)) begin
      n_fail++; $display("FAIL wrap_count: got %0d want 1", bus.instr_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_alu_ops();
    test_illegal();
    test_timeout();
    test_reset_memread();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences the shared datapath (ALU, register file, unified instruction/data memory, immediate sign extender) of the multicycle RV32I core.
- Decodes opcode/funct, drives every datapath enable and mux select including ImmSrc (0 = I-type, 1 = S-type), and handshakes with memory.
- Counts retired instructions.
- Traps on illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles to wait for mem_ready in a memory state before a bus-error trap (must be ≥ 1).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- op  in  7  instruction opcode, from the instruction register
- funct3  in  3  instruction bits 14:12
- funct7b5  in  1  instruction bit 30
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load instruction register and OldPC
- PCWrite  out  1  load PC
- AdrSrc  out  1  address select: 0 = PC, 1 = ALUOut
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = 4
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  1  sign-extender format: 0 = I-type, 1 = S-type
- trap  out  1  controller halted
- trap_cause  out  2  00 none, 01 illegal opcode, 10 bus timeout
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Clocking: clk only. reset is synchronous, active-high, and takes priority over all other state updates, including mid-instruction and during a memory wait. On reset: state = FETCH, wait counter = 0, instr_count = 0, trap = 0, trap_cause = 00.
- Output timing: all control outputs decode combinationally from the state register. ALUControl and ImmSrc also decode from the instruction fields. Unlisted outputs are 0 in every state.
- ImmSrc = 1 when op = 0100011, otherwise 0.
- FETCH: mem_req = 1, AdrSrc = 0. When mem_ready = 1: IRWrite = 1, PCWrite = 1, ALUSrcA = 00, ALUSrcB = 10, ALUControl = add, ResultSrc = 10; go to DECODE. Otherwise stay in FETCH.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, add.
  - op 0000011 or 0100011 -> MEMADR
  - op 0110011 -> EXECR
  - op 0010011 -> EXECI
  - any other op -> TRAP with cause 01
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, add. Go to MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req = 1, AdrSrc = 1. Stay until mem_ready = 1, then go to MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1; retire; go to FETCH.
- MEMWRITE: mem_req = 1, AdrSrc = 1. MemWrite = mem_req & mem_ready. On mem_ready = 1: retire; go to FETCH.
- EXECR: ALUSrcA = 10, ALUSrcB = 00 -> ALUWB.
- EXECI: ALUSrcA = 10, ALUSrcB = 01 -> ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1; retire; go to FETCH.
- ALU decode (EXECR/EXECI):
  - funct3 000: sub if (op = 0110011 and funct7b5 = 1), else add
  - funct3 010: slt
  - funct3 110: or
  - funct3 111: and
  - other funct3 -> TRAP with cause 01, taken in DECODE
- Memory wait counter:
  - cleared on entry to FETCH, MEMREAD and MEMWRITE, and whenever mem_ready = 1
  - increments each waiting cycle
  - when it reaches MEM_TIMEOUT with mem_ready still 0: go to TRAP with cause 10
  - mem_ready is ignored outside the memory states
- Retire: instr_count increments by 1 in the retire cycle and wraps modulo 2^CNT_W.
- TRAP: all strobes 0, trap = 1, trap_cause held. Sticky until reset.
- Minimum latencies with mem_ready tied high: lw 5 cycles, sw 4, R-type 4, I-type 4.

Decomposition:
- Shared package holds:
  - the state encoding (4-bit enum)
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I)
  - ALUControl codes
  - ResultSrc, ALUSrcA and ALUSrcB select codes
  - trap cause codes
- One sub-module: alu_decoder, combinational. Inputs: alu_op class (add / funct), op bit 5, funct3, funct7b5. Outputs: ALUControl and an illegal flag.

Test Plan:
- Reset, then lw (op 0000011, mem_ready always 1) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite = 1 only in cycle 5 with ResultSrc = 01; instr_count = 1.
- sw (op 0100011) with mem_ready low for 3 cycles in MEMWRITE -> ImmSrc = 1 in MEMADR; MemWrite pulses exactly once, on the mem_ready cycle; 7 cycles total; instr_count increments.
- R-type sub (funct3 000, funct7b5 = 1), then addi (op 0010011, funct7b5 = 1) -> ALUControl 001 in EXECR, then 000 with ALUSrcB = 01 in EXECI.
- Illegal op 1111111 -> TRAP from DECODE; trap_cause = 01; no RegWrite, PCWrite or mem_req afterward; reset returns to FETCH with instr_count = 0.
- MEM_TIMEOUT = 4, mem_ready held 0 in FETCH -> trap = 1 with cause 10 after 4 waiting cycles.
- Reset asserted in MEMREAD while mem_ready = 1 -> next cycle is FETCH, no RegWrite, counters cleared.
